// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: F/D and D/E buffer sequencer for load-use stalls, branch flushes and interrupt entry.
// State advances on the falling edge, in step with the stage buffers it controls.
module pipe_hazard_ctrl #(
    parameter int REG_W     = 3,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] i_id_Rsrc1,
    input  logic [REG_W-1:0] i_id_Rsrc2,
    input  logic             i_id_use1,
    input  logic             i_id_use2,
    input  logic             i_ex_mem_rd,
    input  logic [REG_W-1:0] i_ex_Rdst,
    input  logic             i_br_taken,
    input  logic             i_int,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_de_en,
    output logic             o_fd_flush,
    output logic             o_de_flush,
    output logic             o_int_push,
    output logic             o_int_step,
    output logic             o_int_vec,
    output logic [CNT_W-1:0] o_stall_cnt
);
    localparam int DW = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [2:0] {RUN, DRAIN, PUSH_HI, PUSH_LO, VEC} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             lu, stall;
    logic             pc_en, fd_en, de_en, fd_flush, de_flush, int_push, int_step, int_vec;

    assign lu = i_ex_mem_rd & ((i_id_use1 & (i_id_Rsrc1 == i_ex_Rdst)) |
                               (i_id_use2 & (i_id_Rsrc2 == i_ex_Rdst)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b1;
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        int_push = 1'b0;
        int_step = 1'b0;
        int_vec  = 1'b0;
        case (state_q)
            RUN: begin
                if (i_br_taken) begin
                    {pc_en, fd_en, de_en, fd_flush, de_flush} = 5'b11111;
                    stall = 1'b0;
                end else if (i_int) begin
                    fd_en    = 1'b1;
                    de_en    = 1'b1;
                    fd_flush = 1'b1;
                    cnt_d    = DW'(DRAIN_CYC - 1);
                    state_d  = DRAIN;
                end else if (lu) begin
                    de_en    = 1'b1;
                    de_flush = 1'b1;
                end else begin
                    {pc_en, fd_en, de_en} = 3'b111;
                    stall = 1'b0;
                end
            end
            DRAIN: begin
                fd_en    = 1'b1;
                de_en    = 1'b1;
                fd_flush = 1'b1;
                de_flush = 1'b1;
                cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d  = (cnt_q == '0) ? PUSH_HI : DRAIN;
            end
            PUSH_HI: begin
                int_push = 1'b1;
                state_d  = PUSH_LO;
            end
            PUSH_LO: begin
                int_push = 1'b1;
                int_step = 1'b1;
                state_d  = VEC;
            end
            VEC: begin
                int_vec  = 1'b1;
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                fd_flush = 1'b1;
                state_d  = RUN;
            end
            default: begin
                stall   = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
        endcase
        stall_d = (stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Reset forces every control low combinationally, independent of the clock.
    assign o_pc_en     = pc_en & ~rst;
    assign o_fd_en     = fd_en & ~rst;
    assign o_de_en     = de_en & ~rst;
    assign o_fd_flush  = fd_flush & ~rst;
    assign o_de_flush  = de_flush & ~rst;
    assign o_int_push  = int_push & ~rst;
    assign o_int_step  = int_step & ~rst;
    assign o_int_vec   = int_vec & ~rst;
    assign o_stall_cnt = stall_q;
endmodule
